// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, line levels, default widths,
// supported prescale values and the parity helper used by TX and RX.
package uart_pkg;

  localparam int DATA_WIDTH_DEF     = 8;
  localparam int PRESCALE_WIDTH_DEF = 6;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam int PRESCALE_4  = 4;
  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Parity over a zero-extended word; extension bits do not change the result.
  // odd=0 -> even parity (^data), odd=1 -> odd parity (~^data).
  function automatic logic calc_parity(input logic [31:0] data, input logic odd);
    return odd ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Per-bit clock counter. Latches the prescale on load and pulses bit_tick
// on the last clock of every bit while the transmitter is running.
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic                      run,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      bit_tick
);

  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [PRESCALE_WIDTH-1:0] cnt_q;
  logic [PRESCALE_WIDTH-1:0] last_cnt;

  // Prescale values of 0 or 1 collapse to one clock per bit.
  always_comb begin
    last_cnt = '0;
    if (prescale_q > PRESCALE_WIDTH'(1)) begin
      last_cnt = prescale_q - PRESCALE_WIDTH'(1);
    end
  end

  assign bit_tick = run && (cnt_q == last_cnt);

  // Counter restarts on every accepted frame and wraps at the end of each bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_q <= '0;
      cnt_q      <= '0;
    end else if (load) begin
      prescale_q <= prescale;
      cnt_q      <= '0;
    end else if (run) begin
      if (bit_tick) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + PRESCALE_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional
// parity, stop bit. TX_OUT and Busy are driven straight from flops.
// DATA_WIDTH must not exceed 32 (parity helper width).
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int PRESCALE_WIDTH = PRESCALE_WIDTH_DEF
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      Parity_en,
  input  logic                      Parity_type,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      TX_OUT,
  output logic                      Busy
);

  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  accept;
  logic                  bit_tick;

  assign accept = (state == IDLE) && DATA_VALID;

  uart_tx_bit_timer #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_bit_timer (
    .clk     (CLK),
    .rst_n   (RST),
    .load    (accept),
    .run     (Busy),
    .prescale(Prescale),
    .bit_tick(bit_tick)
  );

  // Frame sequencer; the line level for the next bit is registered on the
  // same edge that enters the bit, so TX_OUT never passes through logic.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      shift_q   <= '0;
      bit_cnt   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      TX_OUT    <= STOP_BIT;
      Busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          TX_OUT <= STOP_BIT;
          if (DATA_VALID) begin
            shift_q   <= P_DATA;
            par_en_q  <= Parity_en;
            par_bit_q <= calc_parity(32'(P_DATA), Parity_type);
            bit_cnt   <= '0;
            TX_OUT    <= START_BIT;
            Busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (bit_tick) begin
            TX_OUT  <= shift_q[0];
            shift_q <= shift_q >> 1;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              if (par_en_q) begin
                TX_OUT <= par_bit_q;
                state  <= PARITY;
              end else begin
                TX_OUT <= STOP_BIT;
                state  <= STOP;
              end
            end else begin
              TX_OUT  <= shift_q[0];
              shift_q <= shift_q >> 1;
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
          end
        end
        PARITY: begin
          if (bit_tick) begin
            TX_OUT <= STOP_BIT;
            state  <= STOP;
          end
        end
        STOP: begin
          if (bit_tick) begin
            TX_OUT <= STOP_BIT;
            Busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          TX_OUT <= STOP_BIT;
          Busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: expected frames are queued when a request
// is driven and checked clock-by-clock against the serial line.
module tb_uart_tx;
  import uart_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       DATA_VALID = 1'b0;
  logic       Parity_en = 1'b0;
  logic       Parity_type = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic       TX_OUT;
  logic       Busy;

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       ptype;
    logic [5:0] ps;
  } frame_t;

  frame_t exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  uart_tx dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .Parity_en  (Parity_en),
    .Parity_type(Parity_type),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drive one request; inputs are scrambled right after the accepting edge.
  task automatic send(input logic [7:0] d, input logic pen, input logic ptype,
                      input logic [5:0] ps, input bit push);
    frame_t f;
    @(negedge CLK);
    P_DATA = d; Parity_en = pen; Parity_type = ptype; Prescale = ps;
    DATA_VALID = 1'b1;
    if (push) begin
      f.data = d; f.pen = pen; f.ptype = ptype; f.ps = ps;
      exp_q.push_back(f);
    end
    @(posedge CLK);
    #1;
    DATA_VALID = 1'b0;
    P_DATA = ~d; Parity_en = ~pen; Parity_type = ~ptype; Prescale = 6'd5;
  endtask

  // Pop one expected frame and check every clock of it plus the idle clock.
  task automatic check_frame(output int gap);
    frame_t f;
    logic   bits[0:10];
    logic [7:0] rx_byte;
    int nb, p, bad, busy_cnt;
    gap = 0;
    if (exp_q.size() == 0) begin
      chk("sb_depth", exp_q.size(), 1);
      return;
    end
    f = exp_q.pop_front();
    @(negedge CLK);
    gap = 1;
    while (TX_OUT !== 1'b0 && gap < 1000) begin
      @(negedge CLK);
      gap++;
    end
    if (TX_OUT !== 1'b0) begin
      chk("start_seen", TX_OUT, 0);
      return;
    end
    p = (f.ps < 2) ? 1 : int'(f.ps);
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = f.data[i];
    nb = 9;
    if (f.pen) begin
      bits[9] = f.ptype ? ~(^f.data) : (^f.data);
      nb = 10;
    end
    bits[nb] = 1'b1;
    nb = nb + 1;
    rx_byte = 8'h00;
    busy_cnt = 0;
    for (int b = 0; b < nb; b++) begin
      bad = 0;
      for (int c = 0; c < p; c++) begin
        if (TX_OUT !== bits[b]) bad++;
        if (Busy === 1'b1) busy_cnt++;
        if (c == p / 2 && b >= 1 && b <= 8) rx_byte[b-1] = TX_OUT;
        @(negedge CLK);
      end
      chk($sformatf("d%02h_bit%0d_bad_clocks", f.data, b), bad, 0);
    end
    chk($sformatf("d%02h_rx_data", f.data), rx_byte, f.data);
    chk($sformatf("d%02h_busy_len", f.data), busy_cnt, nb * p);
    chk($sformatf("d%02h_idle_tx", f.data), TX_OUT, 1);
    chk($sformatf("d%02h_idle_busy", f.data), Busy, 0);
  endtask

  initial begin
    int g, g2, n;
    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_tx", TX_OUT, 1);
    chk("rst_busy", Busy, 0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("post_rst_tx", TX_OUT, 1);

    // Odd parity, prescale 8
    send(8'h07, 1'b1, 1'b1, 6'(PRESCALE_8), 1'b1);
    check_frame(g);

    // Even parity, prescale 16
    send(8'h1F, 1'b1, 1'b0, 6'(PRESCALE_16), 1'b1);
    check_frame(g);

    // No parity, prescale 4
    send(8'h07, 1'b0, 1'b0, 6'(PRESCALE_4), 1'b1);
    check_frame(g);

    // Request and data changes mid-frame are ignored
    send(8'h3C, 1'b1, 1'b1, 6'(PRESCALE_8), 1'b1);
    fork
      check_frame(g);
      begin
        repeat (30) @(negedge CLK);
        P_DATA = 8'hA5; DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        repeat (20) @(negedge CLK);
        P_DATA = 8'hFF; Parity_type = 1'b0;
      end
    join
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) n++;
    end
    chk("dropped_req_activity", n, 0);

    // Back-to-back with DATA_VALID held high
    @(negedge CLK);
    P_DATA = 8'h0E; Parity_en = 1'b0; Parity_type = 1'b0;
    Prescale = 6'(PRESCALE_32); DATA_VALID = 1'b1;
    exp_q.push_back('{data: 8'h0E, pen: 1'b0, ptype: 1'b0, ps: 6'(PRESCALE_32)});
    exp_q.push_back('{data: 8'h07, pen: 1'b0, ptype: 1'b0, ps: 6'(PRESCALE_32)});
    fork
      begin
        @(posedge CLK);
        #1 P_DATA = 8'h07;
        n = 0;
        do begin
          @(negedge CLK);
          n++;
        end while (Busy === 1'b1 && n < 2000);
        @(posedge CLK);
        #1 DATA_VALID = 1'b0;
      end
      begin
        check_frame(g);
        check_frame(g2);
        chk("b2b_gap_clocks", g2, 1);
      end
    join

    // Asynchronous reset during D3, then a clean frame
    send(8'hF0, 1'b0, 1'b0, 6'(PRESCALE_8), 1'b0);
    repeat (35) @(negedge CLK);
    chk("pre_rst_d3", TX_OUT, 0);
    #2 RST = 1'b0;
    #1;
    chk("async_rst_tx", TX_OUT, 1);
    chk("async_rst_busy", Busy, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    send(8'h55, 1'b1, 1'b0, 6'(PRESCALE_8), 1'b1);
    check_frame(g);

    // Illegal prescale 0 behaves as one clock per bit
    send(8'hA5, 1'b1, 1'b1, 6'd0, 1'b1);
    check_frame(g);

    chk("sb_leftover", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter: serializes one 8-bit word per frame onto TX_OUT, LSB first, with optional parity.
- Frame format: start(0), D0..D7, optional parity, stop(1).
- Runs on the same oversampled clock as the UART receiver. Each bit is held for Prescale clock cycles, so one frame built here is received correctly by the RX block at matching settings.
- Sits between the system-side data producer and the serial line.

Parameters:
- DATA_WIDTH, 8, payload bits per frame
- PRESCALE_WIDTH, 6, width of the Prescale input

Ports:
- CLK  input  1  oversampled clock (Prescale × bit rate)
- RST  input  1  asynchronous active-low reset
- P_DATA  input  DATA_WIDTH  parallel word to transmit
- DATA_VALID  input  1  request: P_DATA is valid this cycle
- Parity_en  input  1  1 = insert parity bit after D7
- Parity_type  input  1  0 = even, 1 = odd (total ones in data plus parity)
- Prescale  input  PRESCALE_WIDTH  clocks per bit; legal values 4, 8, 16, 32
- TX_OUT  output  1  serial line, idles high
- Busy  output  1  frame in progress; DATA_VALID is ignored while high

Behaviour:
- Reset (RST low, asynchronous):
  - TX_OUT=1, Busy=0, state=IDLE.
  - Bit counter, clock counter and shift register are cleared.
  - Reset mid-frame aborts the frame immediately; TX_OUT returns to 1 with no glitch to 0.
- States:
  - IDLE → START (DATA_VALID=1)
  - START → DATA (after Prescale cycles)
  - DATA → PARITY (after 8 bits, Parity_en latched 1), otherwise DATA → STOP
  - PARITY → STOP
  - STOP → IDLE
- Acceptance:
  - In IDLE, DATA_VALID=1 at a rising edge latches P_DATA, Parity_en, Parity_type and Prescale.
  - Input changes during the frame have no effect.
  - DATA_VALID while Busy=1 is dropped; there is no queueing.
- Latency: TX_OUT falls to 0 and Busy rises on the first edge after acceptance. Both are registered outputs.
- Bit timing:
  - Clock counter counts 0..Prescale_latched−1. A bit advances when counter == Prescale_latched−1.
  - Every bit, start and stop included, lasts exactly Prescale_latched cycles.
- Data: DATA state shifts the register right; TX_OUT = shift[0]. The bit counter runs 0..7.
- Parity:
  - Computed from the latched word at acceptance.
  - Even: bit = ^data. Odd: bit = ~^data.
- Stop and release:
  - STOP drives 1 for Prescale_latched cycles, then the state goes to IDLE. Busy falls on the same edge.
  - TX_OUT stays 1 in IDLE.
  - Minimum inter-frame gap: one clock of mark after the stop bit, since DATA_VALID is sampled in IDLE.
- Frame length: 10 bits (no parity) or 11 bits (parity), × Prescale_latched cycles, plus one IDLE cycle.
- Illegal Prescale: 0 or 1 latched are treated as 1 (one clock per bit). Other non-listed values are used as given.
- Outputs are glitch-free: TX_OUT comes straight from a flop, not from a combinational mux.

Decomposition:
- Shared package (uart_pkg):
  - state enum IDLE/START/DATA/PARITY/STOP
  - START_BIT=0, STOP_BIT=1
  - DATA_WIDTH and PRESCALE_WIDTH defaults
  - legal prescale constants 4/8/16/32
- Also in the package: the parity function, shared with the RX parity checker.
- One natural sub-module: uart_tx_bit_timer. It is the clock counter with a bit_tick output, reloaded on acceptance and reused for each bit.

Test Plan:
- Reset then P_DATA=0x07, Parity_en=1, Parity_type=1, Prescale=8 → TX_OUT sequence 0,1,1,1,0,0,0,0,0,0(parity),1, each bit 8 clocks. Busy high for 88 clocks.
- P_DATA=0x1F, even parity, Prescale=16 → parity bit 1, stop 1; each bit 16 clocks. Loop TX_OUT into the RX block: it reports 0x1F with no errors.
- P_DATA=0x07, Parity_en=0, Prescale=4 → 10-bit frame of 40 clocks with no parity slot. Busy falls after the stop bit.
- Second DATA_VALID pulse (0xA5) mid-frame, then P_DATA changed to 0xFF before the frame ends → transmitted word is still the first one. 0xA5 is dropped.
- Back-to-back: DATA_VALID held high with 0x0E then 0x07, Prescale=32 → two frames separated by exactly one idle clock of TX_OUT=1.
- RST low during D3 of a frame → TX_OUT=1 and Busy=0 asynchronously. After release, a new 0x55 frame transmits correctly.
